// File: rtl/divider_if.sv
// Operand/result bundle between the picoMIPS controller (master) and the
// iterative divider (slave).
interface divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, WIDTH+1
// edges from the accepting edge to the done cycle. All outputs are registered.
module divider #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     n_reset,
    divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic [WIDTH-1:0] dvsr_q,  dvsr_d;
    logic [WIDTH-1:0] quot_q,  quot_d;
    logic [WIDTH-1:0] rmdr_q,  rmdr_d;
    logic             dbz_q,   dbz_d;

    // The partial remainder always stays below the divisor (or equals a dividend
    // prefix when dividing by zero), so WIDTH stored bits suffice; the extra bit
    // of the WIDTH+1 trial is the borrow.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    assign shifted = {rem_q, q_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvsr_q};

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path
        // through the case leaves it unassigned, which would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        q_d     = q_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        rmdr_d  = rmdr_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = CW'(WIDTH);
                    rem_d   = '0;
                    q_d     = bus.dividend;
                    dvsr_d  = bus.divisor;
                    dbz_d   = (bus.divisor == '0);
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    q_d   = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    q_d   = {q_q[WIDTH-2:0], 1'b0};
                end
                // Results are captured only on the final step so they stay
                // stable until the next division finishes.
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    quot_d  = q_d;
                    rmdr_d  = rem_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            rmdr_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            rmdr_q  <= rmdr_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rmdr_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/divider.md
# divider

Iterative unsigned restoring divider for the picoMIPS datapath. It is the inverse companion of the multiplier-based arithmetic and computes one quotient bit per clock, so it costs no dedicated multiplier or divider blocks. It sits beside the ALU. The controller issues a start pulse with two operands and holds the pipeline until done.

## Interface
- WIDTH, 8: operand, quotient and remainder width in bits; must be ≥ 2.

- clk  in  1  system clock; all state updates on the rising edge.
- n_reset  in  1  reset; asynchronous assert, active-low.
- start  in  1  request; sampled on the rising edge and accepted only when the block is ready.
- dividend  in  WIDTH  unsigned numerator; sampled on the accepting edge only.
- divisor  in  WIDTH  unsigned denominator; sampled on the accepting edge only.
- busy  out  1  high while a division is in progress.
- done  out  1  single-cycle pulse; high when the results are first valid.
- quotient  out  WIDTH  unsigned quotient; held until the next accepted start.
- remainder  out  WIDTH  unsigned remainder; held until the next accepted start.
- div_by_zero  out  1  high when the last accepted divisor was 0; held with the results.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → latch the operands, clear the partial remainder, load the bit counter with WIDTH, go to RUN.
  - start=0 → stay in IDLE.
- RUN:
  - Each edge performs one restoring step, then decrements the counter.
  - When the counter reaches 0 after a step, go to DONE.
  - start is ignored while in RUN.
- DONE:
  - done=1 for exactly this one cycle.
  - start=1 → accepted exactly as in IDLE (back-to-back operation), go to RUN.
  - start=0 → go to IDLE.
- Restoring step:
  - Use an internal partial remainder of WIDTH+1 bits and a quotient shift register of WIDTH bits.
  - Form trial = {rem[WIDTH-1:0], q[WIDTH-1]} − {1'b0, divisor}.
  - If there is no borrow (trial MSB = 0): rem ← trial and shift 1 into q LSB.
  - Otherwise: rem ← the shifted value and shift 0 into q LSB.
  - q shifts left, consuming dividend bits MSB first.
- quotient and remainder are driven from the result registers; they are not combinational from the inputs.
- Divide by zero needs no special-case datapath. The normal algorithm yields quotient = all ones and remainder = dividend.
  - div_by_zero is registered from (divisor == 0) at the accepting edge.
  - The result is reported with the normal latency.
- busy=1 in RUN only. busy=0 in IDLE and DONE.
- Reset (n_reset=0, at any time, including mid-RUN or in DONE):
  - Immediately force IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
  - Any in-flight division is discarded.
  - The first start is recognised on the first rising edge after n_reset deasserts.
- Changing dividend or divisor while in RUN has no effect on the current division.

## Timing
- Let edge E0 be the accepting edge (start=1 in IDLE or DONE).
- busy is high from after E0 until after edge E0+WIDTH.
- The WIDTH restoring steps occur on edges E0+1 … E0+WIDTH.
- done, quotient, remainder and div_by_zero are valid after edge E0+WIDTH. They are stable during the cycle before E0+WIDTH+1.
- Latency is start edge to done cycle = WIDTH+1 edges, i.e. 9 for WIDTH=8.
- Maximum throughput is one division per WIDTH+1 cycles, by asserting start during each DONE cycle.
- There are no combinational paths from any input to any output.

## Test plan
- Reset release, then start with dividend=100, divisor=7 (WIDTH=8):
  - busy high for 8 cycles, then done pulses for exactly 1 cycle.
  - quotient=14, remainder=2, div_by_zero=0.
  - Results hold after done falls.
- Boundary values, each run separately:
  - 255/1 → quotient=255, remainder=0.
  - 200/250 → quotient=0, remainder=200.
  - 255/255 → quotient=1, remainder=0.
- Divide by zero, dividend=5, divisor=0:
  - done arrives with the normal latency.
  - quotient=255, remainder=5, div_by_zero=1.
  - A following 6/3 clears the flag and gives quotient=2, remainder=0.
- Start 50/5, then during RUN pulse start with 9/2 and change the operand inputs:
  - The second request is ignored; busy is unaffected.
  - The result is quotient=10, remainder=0.
- Back-to-back: start 77/8, then assert start with 13/4 in the done cycle:
  - First result is 9 r 5.
  - busy re-asserts with no idle cycle.
  - Second done occurs 9 cycles later with 3 r 1.
- Assert n_reset=0 asynchronously mid-RUN (between edges):
  - All outputs go to 0 immediately and the state returns to IDLE.
  - After release, a new 100/7 completes correctly with quotient=14, remainder=2.
